fp_norm_shift_pipe: RTL and testbench

- Parametrised, pipelined left-normalization shifter for the FP add/sub datapath; sits after the add stage and before rounding.
- Shifts a mantissa left by a requested amount, one radix-4 level per pipeline stage, so a wide shift never sits in one combinational path.
- Adjusts the exponent, flags bits lost off the top and exponent underflow.
- Carries a valid/ready handshake so the FP pipeline can stall.

---
 rtl/fp_norm_shift_pipe_pkg.sv | 38 +++
 rtl/fp_norm_shift_pipe_if.sv | 35 +++
 rtl/fp_norm_shift_lvl.sv | 58 +++++
 rtl/fp_norm_shift_pipe.sv | 129 ++++++++++++
 tb/tb_fp_norm_shift_pipe.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_norm_shift_pipe_pkg.sv
// Shared constants, stage record and helpers for the FP normalize-shift pipe.
//   FP_MAN_W / FP_SHIFT_W / FP_EXP_W : default datapath widths
//   stage_t : one pipeline stage {valid, mant, shift, exp, ovf, unf} at the
//             default widths (parameterised modules carry the same fields as
//             separate vectors so that non-default widths still work)
//   nlvl()  : radix-4 levels needed for a shift-amount width
//   lzc()   : leading-zero count of the low w bits of v (lzc of zero = w)
package fp_pipe_pkg;

    localparam int FP_MAN_W   = 26;
    localparam int FP_SHIFT_W = 5;
    localparam int FP_EXP_W   = 8;
    localparam int LZC_MAX_W  = 64;

    typedef struct packed {
        logic                  valid;
        logic [FP_MAN_W-1:0]   mant;
        logic [FP_SHIFT_W-1:0] shift;
        logic [FP_EXP_W-1:0]   exp;
        logic                  ovf;
        logic                  unf;
    } stage_t;

    function automatic int nlvl(input int shift_w);
        return (shift_w + 1) / 2;
    endfunction

    // Scans upward so the last hit is the highest set bit.
    function automatic int lzc(input logic [LZC_MAX_W-1:0] v, input int w);
        int n;
        n = w;
        for (int i = 0; i < LZC_MAX_W; i++) begin
            if (i < w && v[i]) n = w - 1 - i;
        end
        return n;
    endfunction

endpackage

// File: rtl/fp_norm_shift_pipe_if.sv
// Handshake/data bundle of the normalize-shift pipe.
//   in_*  : input beat (valid/ready, mant, shift, exp, auto)
//   out_* : output beat (valid/ready, mant, exp, ovf, unf)
//   master : producer/consumer side (drives in_* and out_ready)
//   slave  : the pipe itself
interface fp_norm_shift_pipe_if
    import fp_pipe_pkg::*;
#(
    parameter int MAN_W   = FP_MAN_W,
    parameter int SHIFT_W = FP_SHIFT_W,
    parameter int EXP_W   = FP_EXP_W
);
    logic               in_valid;
    logic               in_ready;
    logic [MAN_W-1:0]   in_mant;
    logic [SHIFT_W-1:0] in_shift;
    logic [EXP_W-1:0]   in_exp;
    logic               in_auto;
    logic               out_valid;
    logic               out_ready;
    logic [MAN_W-1:0]   out_mant;
    logic [EXP_W-1:0]   out_exp;
    logic               out_ovf;
    logic               out_unf;

    modport master (
        output in_valid, in_mant, in_shift, in_exp, in_auto, out_ready,
        input  in_ready, out_valid, out_mant, out_exp, out_ovf, out_unf
    );

    modport slave (
        input  in_valid, in_mant, in_shift, in_exp, in_auto, out_ready,
        output in_ready, out_valid, out_mant, out_exp, out_ovf, out_unf
    );
endinterface

// File: rtl/fp_norm_shift_lvl.sv
// One radix-4 level of the normalize shifter plus its stage register.
// Shifts left by shift[2*LVL+1:2*LVL] * 4^LVL; bits pushed past the top are
// ORed into ovf. exp/unf/shift ride along untouched.
//   clk, rst : clock, synchronous active-high reset
//   en       : stage advance enable
//   up_*     : fields from the previous stage
//   valid, mant, shift, exp, ovf, unf : registered stage fields
module fp_norm_shift_lvl #(
    parameter int MAN_W   = 26,
    parameter int SHIFT_W = 5,
    parameter int EXP_W   = 8,
    parameter int LVL     = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               up_valid,
    input  logic [MAN_W-1:0]   up_mant,
    input  logic [SHIFT_W-1:0] up_shift,
    input  logic [EXP_W-1:0]   up_exp,
    input  logic               up_ovf,
    input  logic               up_unf,
    output logic               valid,
    output logic [MAN_W-1:0]   mant,
    output logic [SHIFT_W-1:0] shift,
    output logic [EXP_W-1:0]   exp,
    output logic               ovf,
    output logic               unf
);
    logic [1:0]         dig;
    logic [2*MAN_W-1:0] wide;

    // On the top level of an odd SHIFT_W the upper digit bit shifts in as 0.
    always_comb begin
        dig  = 2'(up_shift >> (2 * LVL));
        wide = {{MAN_W{1'b0}}, up_mant} << (int'(dig) << (2 * LVL));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            mant  <= '0;
            shift <= '0;
            exp   <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (en) begin
            valid <= up_valid;
            if (up_valid) begin
                mant  <= wide[MAN_W-1:0];
                shift <= up_shift;
                exp   <= up_exp;
                ovf   <= up_ovf | (|wide[2*MAN_W-1:MAN_W]);
                unf   <= up_unf;
            end
        end
    end
endmodule

// File: rtl/fp_norm_shift_pipe.sv
// Pipelined left-normalization shifter (after FP add, before rounding).
// One radix-4 level per stage; exponent adjusted and underflow detected up
// front; ovf collects every bit shifted off the top. valid/ready stalls.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fp_norm_shift_pipe_if.slave (in_* beat, out_* beat)
// Build option FPNS_AUTO_LZC_EN: adds a pre-stage that, when in_auto = 1,
// replaces in_shift with min(lzc(in_mant), in_exp, 2^SHIFT_W-1). Latency
// becomes NLVL+1. Without it in_auto is ignored.
module fp_norm_shift_pipe
    import fp_pipe_pkg::*;
#(
    parameter int MAN_W   = FP_MAN_W,
    parameter int SHIFT_W = FP_SHIFT_W,
    parameter int EXP_W   = FP_EXP_W
) (
    input logic                 clk,
    input logic                 rst,
    fp_norm_shift_pipe_if.slave bus
);
    localparam int NLVL = nlvl(SHIFT_W);

    // Index 0 is the head feeding level 0; index k+1 is level k's register.
    logic [NLVL:0]              vld_pipe;
    logic [NLVL:0][MAN_W-1:0]   mant_pipe;
    logic [NLVL:0][SHIFT_W-1:0] shift_pipe;
    logic [NLVL:0][EXP_W-1:0]   exp_pipe;
    logic [NLVL:0]              ovf_pipe;
    logic [NLVL:0]              unf_pipe;
    logic [NLVL-1:0]            en;

    logic               h_valid;
    logic [MAN_W-1:0]   h_mant;
    logic [SHIFT_W-1:0] h_shift;
    logic [EXP_W-1:0]   h_exp;
    logic [EXP_W:0]     diff;

`ifdef FPNS_AUTO_LZC_EN
    localparam int MAX_SHIFT = (1 << SHIFT_W) - 1;

    logic               pre_valid;
    logic [MAN_W-1:0]   pre_mant;
    logic [SHIFT_W-1:0] pre_shift;
    logic [EXP_W-1:0]   pre_exp;
    logic [SHIFT_W-1:0] eff_shift;
    logic               en_pre;
    int                 lz;

    // Clamping to in_exp keeps the later subtract borrow-free in auto mode.
    always_comb begin
        lz = lzc(LZC_MAX_W'(bus.in_mant), MAN_W);
        if (lz > int'(bus.in_exp)) lz = int'(bus.in_exp);
        if (lz > MAX_SHIFT)        lz = MAX_SHIFT;
        eff_shift = bus.in_auto ? SHIFT_W'(lz) : bus.in_shift;
    end

    assign en_pre       = !pre_valid | en[0];
    assign bus.in_ready = en_pre;

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_valid <= 1'b0;
            pre_mant  <= '0;
            pre_shift <= '0;
            pre_exp   <= '0;
        end else if (en_pre) begin
            pre_valid <= bus.in_valid;
            if (bus.in_valid) begin
                pre_mant  <= bus.in_mant;
                pre_shift <= eff_shift;
                pre_exp   <= bus.in_exp;
            end
        end
    end

    assign h_valid = pre_valid;
    assign h_mant  = pre_mant;
    assign h_shift = pre_shift;
    assign h_exp   = pre_exp;
`else
    wire unused_auto = &{1'b0, bus.in_auto};

    assign bus.in_ready = en[0];
    assign h_valid      = bus.in_valid;
    assign h_mant       = bus.in_mant;
    assign h_shift      = bus.in_shift;
    assign h_exp        = bus.in_exp;
`endif

    // Borrow out of the extra MSB marks underflow; exponent then floors at 0.
    assign diff = {1'b0, h_exp} - (EXP_W + 1)'(h_shift);

    always_comb begin
        vld_pipe[0]   = h_valid;
        mant_pipe[0]  = h_mant;
        shift_pipe[0] = h_shift;
        exp_pipe[0]   = diff[EXP_W] ? '0 : diff[EXP_W-1:0];
        ovf_pipe[0]   = 1'b0;
        unf_pipe[0]   = diff[EXP_W];
    end

    // A stage may load when it is empty or its successor is loading.
    always_comb begin
        en         = '0;
        en[NLVL-1] = !vld_pipe[NLVL] | bus.out_ready;
        for (int k = NLVL - 2; k >= 0; k--) en[k] = !vld_pipe[k+1] | en[k+1];
    end

    for (genvar k = 0; k < NLVL; k++) begin : g_lvl
        fp_norm_shift_lvl #(
            .MAN_W(MAN_W), .SHIFT_W(SHIFT_W), .EXP_W(EXP_W), .LVL(k)
        ) u_lvl (
            .clk(clk), .rst(rst), .en(en[k]),
            .up_valid(vld_pipe[k]), .up_mant(mant_pipe[k]),
            .up_shift(shift_pipe[k]), .up_exp(exp_pipe[k]),
            .up_ovf(ovf_pipe[k]), .up_unf(unf_pipe[k]),
            .valid(vld_pipe[k+1]), .mant(mant_pipe[k+1]),
            .shift(shift_pipe[k+1]), .exp(exp_pipe[k+1]),
            .ovf(ovf_pipe[k+1]), .unf(unf_pipe[k+1])
        );
    end

    wire unused_shift = &{1'b0, shift_pipe[NLVL]};

    assign bus.out_valid = vld_pipe[NLVL];
    assign bus.out_mant  = mant_pipe[NLVL];
    assign bus.out_exp   = exp_pipe[NLVL];
    assign bus.out_ovf   = ovf_pipe[NLVL];
    assign bus.out_unf   = unf_pipe[NLVL];
endmodule

// File: tb/tb_fp_norm_shift_pipe.sv
// Self-checking bench for fp_norm_shift_pipe: directed cases, backpressure,
// mid-flight reset and a random stream, against an arithmetic model.
module tb_fp_norm_shift_pipe;
    import fp_pipe_pkg::*;

    localparam int MAN_W   = FP_MAN_W;
    localparam int SHIFT_W = FP_SHIFT_W;
    localparam int EXP_W   = FP_EXP_W;
    localparam int NLVL    = nlvl(SHIFT_W);
`ifdef FPNS_AUTO_LZC_EN
    localparam int  DEPTH   = NLVL + 1;
    localparam bit  AUTO_EN = 1'b1;
`else
    localparam int  DEPTH   = NLVL;
    localparam bit  AUTO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_norm_shift_pipe_if #(.MAN_W(MAN_W), .SHIFT_W(SHIFT_W), .EXP_W(EXP_W)) bus ();

    fp_norm_shift_pipe #(.MAN_W(MAN_W), .SHIFT_W(SHIFT_W), .EXP_W(EXP_W)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int     n_checks = 0;
    int     n_err    = 0;
    stage_t q[$];
    int     occ = 0;
    int     cyc = 0;
    logic   acc, fired, last_rdy;
    int     acc_cyc, out_cyc;
    logic [MAN_W-1:0] last_mant;
    logic [EXP_W-1:0] last_exp;
    logic             last_ovf, last_unf;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Shift by the requested (or auto-derived) amount in 64-bit arithmetic.
    function automatic stage_t model(input logic [MAN_W-1:0] m, input logic [SHIFT_W-1:0] s,
                                     input logic [EXP_W-1:0] e, input logic a);
        stage_t          r;
        int              sh;
        int              lz;
        logic            use_auto;
        longint unsigned full;
        use_auto = a & AUTO_EN;
        sh = int'(s);
        if (use_auto) begin
            lz = MAN_W;
            for (int i = 0; i < MAN_W; i++) if (m[i]) lz = MAN_W - 1 - i;
            sh = lz;
            if (sh > int'(e)) sh = int'(e);
            if (sh > (1 << SHIFT_W) - 1) sh = (1 << SHIFT_W) - 1;
        end
        full    = 64'(m) << sh;
        r.valid = 1'b1;
        r.mant  = full[MAN_W-1:0];
        r.shift = SHIFT_W'(sh);
        r.ovf   = (full >> MAN_W) != 0;
        if (sh > int'(e)) begin
            r.unf = 1'b1;
            r.exp = '0;
        end else begin
            r.unf = 1'b0;
            r.exp = EXP_W'(int'(e) - sh);
        end
        return r;
    endfunction

    // One clock: sample handshakes away from the edge, then advance.
    task automatic tick();
        stage_t e;
        acc   = 1'b0;
        fired = 1'b0;
        #1;
        last_rdy = bus.in_ready;
        if (!rst) begin
            check("in_ready", 64'(bus.in_ready), 64'(!(occ == DEPTH && !bus.out_ready)));
            if (bus.out_valid && bus.out_ready) begin
                fired = 1'b1; out_cyc = cyc;
                last_mant = bus.out_mant; last_exp = bus.out_exp;
                last_ovf  = bus.out_ovf;  last_unf = bus.out_unf;
                if (q.size() == 0) begin
                    check("spurious_out", 64'(bus.out_valid), 64'(0));
                end else begin
                    e = q.pop_front();
                    occ--;
                    check("sb_mant", 64'(bus.out_mant), 64'(e.mant));
                    check("sb_exp",  64'(bus.out_exp),  64'(e.exp));
                    check("sb_ovf",  64'(bus.out_ovf),  64'(e.ovf));
                    check("sb_unf",  64'(bus.out_unf),  64'(e.unf));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                acc = 1'b1; acc_cyc = cyc;
                q.push_back(model(bus.in_mant, bus.in_shift, bus.in_exp, bus.in_auto));
                occ++;
            end
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
            occ = 0;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic send_one(input logic [MAN_W-1:0] m, input logic [SHIFT_W-1:0] s,
                            input logic [EXP_W-1:0] e, input logic a, output int lat);
        int   t;
        logic got;
        bus.in_valid = 1'b1; bus.in_mant = m; bus.in_shift = s;
        bus.in_exp = e; bus.in_auto = a; bus.out_ready = 1'b1;
        tick();
        check("accept", 64'(acc), 64'(1));
        bus.in_valid = 1'b0;
        t = 0; got = 1'b0;
        while (!got && t < 20) begin
            tick();
            if (fired) got = 1'b1;
            t++;
        end
        check("out_timeout", 64'(got), 64'(1));
        lat = out_cyc - acc_cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, sent, rcv, t;
        logic stall_seen;
        logic [MAN_W-1:0] cur;

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_mant = '0; bus.in_shift = '0;
        bus.in_exp = '0; bus.in_auto = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);
        tick(); tick();
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_mant",  64'(bus.out_mant),  64'(0));
        check("rst_out_exp",   64'(bus.out_exp),   64'(0));
        check("rst_out_ovf",   64'(bus.out_ovf),   64'(0));
        check("rst_out_unf",   64'(bus.out_unf),   64'(0));
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
        @(negedge clk);

        // Full-range shift
        send_one(26'h0000001, 5'd25, 8'd100, 1'b0, lat);
        check("full_latency", 64'(lat), 64'(DEPTH));
        check("full_mant", 64'(last_mant), 64'(26'h2000000));
        check("full_exp",  64'(last_exp),  64'(75));
        check("full_ovf",  64'(last_ovf),  64'(0));
        check("full_unf",  64'(last_unf),  64'(0));

        // Bit lost off the top
        send_one(26'h3000000, 5'd1, 8'd10, 1'b0, lat);
        check("ovf_mant", 64'(last_mant), 64'(26'h2000000));
        check("ovf_exp",  64'(last_exp),  64'(9));
        check("ovf_flag", 64'(last_ovf),  64'(1));

        // Exponent underflow still shifts the mantissa fully
        send_one(26'h0000010, 5'd5, 8'd3, 1'b0, lat);
        check("unf_mant", 64'(last_mant), 64'(26'h0000200));
        check("unf_exp",  64'(last_exp),  64'(0));
        check("unf_flag", 64'(last_unf),  64'(1));

        // Zero shift passes through
        send_one(26'h155AAAA, 5'd0, 8'd77, 1'b0, lat);
        check("zero_mant", 64'(last_mant), 64'(26'h155AAAA));
        check("zero_exp",  64'(last_exp),  64'(77));
        check("zero_ovf",  64'(last_ovf),  64'(0));
        check("zero_unf",  64'(last_unf),  64'(0));

`ifdef FPNS_AUTO_LZC_EN
        send_one(26'h0004000, 5'd0, 8'd200, 1'b1, lat);
        check("auto_latency", 64'(lat), 64'(NLVL + 1));
        check("auto_mant", 64'(last_mant), 64'(26'h2000000));
        check("auto_exp",  64'(last_exp),  64'(189));
        send_one(26'h0004000, 5'd0, 8'd5, 1'b1, lat);
        check("auto_clamp_mant", 64'(last_mant), 64'(26'h0080000));
        check("auto_clamp_exp",  64'(last_exp),  64'(0));
        check("auto_clamp_unf",  64'(last_unf),  64'(0));
`else
        // in_auto must have no effect in this build
        send_one(26'h0004000, 5'd3, 8'd200, 1'b1, lat);
        check("noauto_mant", 64'(last_mant), 64'(26'h0020000));
        check("noauto_exp",  64'(last_exp),  64'(197));
`endif

        // Backpressure: 10 back-to-back beats, out_ready low for cycles 4-7
        sent = 0; rcv = 0; t = 0; stall_seen = 1'b0;
        cur = MAN_W'($urandom() >> 6);
        while (rcv < 10 && t < 60) begin
            bus.out_ready = !(t >= 4 && t <= 7);
            bus.in_valid  = (sent < 10);
            bus.in_mant   = cur;
            bus.in_shift  = SHIFT_W'(sent);
            bus.in_exp    = 8'd50;
            bus.in_auto   = 1'b0;
            tick();
            if (acc) begin
                sent++;
                cur = MAN_W'($urandom() >> 6);
            end
            if (fired) rcv++;
            if (!last_rdy) stall_seen = 1'b1;
            t++;
        end
        bus.in_valid = 1'b0;
        check("bp_count", 64'(rcv), 64'(10));
        check("bp_stall_seen", 64'(stall_seen), 64'(1));
        check("bp_sb_empty", 64'(q.size()), 64'(0));

        // Reset with two beats in flight: neither may ever appear
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_mant = 26'h0000123; bus.in_shift = 5'd2; bus.in_exp = 8'd40;
        tick();
        bus.in_mant = 26'h0000456;
        tick();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        for (int i = 0; i < 8; i++) begin
            tick();
            check("midrst_no_beat", 64'(fired), 64'(0));
        end

        // Random stream with random backpressure
        for (int i = 0; i < 300; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            bus.in_mant   = MAN_W'($urandom() >> $urandom_range(6, 31));
            bus.in_shift  = SHIFT_W'($urandom_range(0, 31));
            bus.in_exp    = EXP_W'($urandom_range(0, 255));
            bus.in_auto   = $urandom_range(0, 1) != 0;
            tick();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        t = 0;
        while (q.size() != 0 && t < 20) begin
            tick();
            t++;
        end
        check("rand_drain", 64'(q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
